// File: rtl/tetris_pkg.sv
// Shared board geometry, FSM state encoding and cell addressing for the
// Tetris board controller.
package tetris_pkg;

  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 12;
  localparam int CELL_BITS   = 4;
  localparam int BOARD_CELLS = BOARD_W * BOARD_H;
  localparam int ADDR_W      = 7;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SCAN,
    S_SHIFT_RD,
    S_SHIFT_WR,
    S_TOPZERO
  } state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
    return ADDR_W'(y) * ADDR_W'(BOARD_W) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/tetris_board_ram.sv
// Single-port board RAM with registered read data (one-cycle latency),
// written so synthesis can map it onto a block RAM.
module tetris_board_ram #(
  parameter int DEPTH = tetris_pkg::BOARD_CELLS,
  parameter int AW    = tetris_pkg::ADDR_W,
  parameter int DW    = tetris_pkg::CELL_BITS
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tetris_board_ctrl.sv
// Board RAM owner: wipes the board, arbitrates game writes against renderer
// reads, and runs the post-lock line-clear engine.
module tetris_board_ctrl #(
  parameter int BOARD_W   = tetris_pkg::BOARD_W,
  parameter int BOARD_H   = tetris_pkg::BOARD_H,
  parameter int CELL_BITS = tetris_pkg::CELL_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_req,
  input  logic [3:0]           wr_x,
  input  logic [3:0]           wr_y,
  input  logic [CELL_BITS-1:0] wr_color,
  output logic                 wr_ack,
  input  logic                 lock_done,
  input  logic                 rd_req,
  input  logic [3:0]           rd_x,
  input  logic [3:0]           rd_y,
  output logic                 rd_ack,
  output logic                 rd_valid,
  output logic [CELL_BITS-1:0] rd_data,
  output logic                 busy,
  output logic                 clear_pulse,
  output logic [2:0]           rows_cleared,
  output logic [9:0]           total_lines
);
  import tetris_pkg::*;

  localparam int         CELLS = BOARD_W * BOARD_H;
  localparam logic [3:0] XMAX  = 4'(BOARD_W - 1);
  localparam logic [3:0] YMAX  = 4'(BOARD_H - 1);

  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [2:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {8'b0, b};
    return s[10] ? 10'h3FF : s[9:0];
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
  logic [3:0]          x_q, x_d, row_q, row_d, dst_q, dst_d, cnt_q, cnt_d;
  logic [2:0]          clr_q, clr_d;
  logic                lock_pend_q, lock_pend_d;
  logic                rd_valid_q, rd_valid_d, rd_oob_q, rd_oob_d;
  logic                clear_pulse_q, clear_pulse_d;
  logic [2:0]          rows_cleared_q, rows_cleared_d;
  logic [9:0]          total_lines_q, total_lines_d;

  logic                ram_en, ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [CELL_BITS-1:0] ram_wdata, ram_rdata;
  logic                wr_in_range, rd_in_range, start_scan, finish;
  logic [3:0]          scan_total;

  tetris_board_ram #(
    .DEPTH(CELLS),
    .AW   (ADDR_W),
    .DW   (CELL_BITS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d        = state_q;
    init_addr_d    = init_addr_q;
    x_d            = x_q;
    row_d          = row_q;
    dst_d          = dst_q;
    cnt_d          = cnt_q;
    clr_d          = clr_q;
    rd_valid_d     = 1'b0;
    rd_oob_d       = rd_oob_q;
    clear_pulse_d  = 1'b0;
    rows_cleared_d = rows_cleared_q;
    total_lines_d  = total_lines_q;
    wr_ack         = 1'b0;
    rd_ack         = 1'b0;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;
    start_scan     = 1'b0;
    finish         = 1'b0;
    wr_in_range    = (wr_x <= XMAX) && (wr_y <= YMAX);
    rd_in_range    = (rd_x <= XMAX) && (rd_y <= YMAX);
    // RAM data in S_SCAN belongs to the cell read on the previous cycle.
    scan_total     = cnt_q + {3'b0, |ram_rdata};

    case (state_q)
      S_INIT: begin
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = init_addr_q;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == ADDR_W'(CELLS - 1)) begin
          init_addr_d = '0;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (wr_req) begin
          wr_ack = 1'b1;
          if (wr_in_range) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = cell_addr(wr_x, wr_y);
            ram_wdata = wr_color;
          end
        end else if (lock_pend_q) begin
          start_scan = 1'b1;
          state_d    = S_SCAN;
          row_d      = YMAX;
          x_d        = '0;
          cnt_d      = '0;
          clr_d      = '0;
        end else if (rd_req) begin
          rd_ack     = 1'b1;
          rd_valid_d = 1'b1;
          rd_oob_d   = !rd_in_range;
          if (rd_in_range) begin
            ram_en   = 1'b1;
            ram_addr = cell_addr(rd_x, rd_y);
          end
        end
      end
      S_SCAN: begin
        if (x_q != 4'd0) cnt_d = scan_total;
        if (x_q <= XMAX) begin
          ram_en   = 1'b1;
          ram_addr = cell_addr(x_q, row_q);
          x_d      = x_q + 4'd1;
        end else begin
          x_d   = '0;
          cnt_d = '0;
          if (scan_total == 4'(BOARD_W)) begin
            clr_d = clr_q + 3'd1;
            if (row_q == 4'd0) begin
              state_d = S_TOPZERO;
            end else begin
              state_d = S_SHIFT_RD;
              dst_d   = row_q;
            end
          end else if (row_q == 4'd0) begin
            finish = 1'b1;
          end else begin
            row_d = row_q - 4'd1;
          end
        end
      end
      S_SHIFT_RD: begin
        ram_en   = 1'b1;
        ram_addr = cell_addr(x_q, dst_q - 4'd1);
        state_d  = S_SHIFT_WR;
      end
      S_SHIFT_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = cell_addr(x_q, dst_q);
        ram_wdata = ram_rdata;
        state_d   = S_SHIFT_RD;
        if (x_q == XMAX) begin
          x_d = '0;
          if (dst_q == 4'd1) state_d = S_TOPZERO;
          else               dst_d   = dst_q - 4'd1;
        end else begin
          x_d = x_q + 4'd1;
        end
      end
      S_TOPZERO: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cell_addr(x_q, 4'd0);
        if (x_q == XMAX) begin
          x_d   = '0;
          cnt_d = '0;
          // The same row is rescanned: it now holds what was above it.
          if (clr_q == 3'd4) finish  = 1'b1;
          else               state_d = S_SCAN;
        end else begin
          x_d = x_q + 4'd1;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (finish) begin
      state_d        = S_IDLE;
      clear_pulse_d  = 1'b1;
      rows_cleared_d = clr_q;
      total_lines_d  = sat_add(total_lines_q, clr_q);
    end

    lock_pend_d = (lock_pend_q && !start_scan) || lock_done;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_INIT;
      init_addr_q    <= '0;
      x_q            <= '0;
      row_q          <= '0;
      dst_q          <= '0;
      cnt_q          <= '0;
      clr_q          <= '0;
      lock_pend_q    <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_oob_q       <= 1'b0;
      clear_pulse_q  <= 1'b0;
      rows_cleared_q <= '0;
      total_lines_q  <= '0;
    end else begin
      state_q        <= state_d;
      init_addr_q    <= init_addr_d;
      x_q            <= x_d;
      row_q          <= row_d;
      dst_q          <= dst_d;
      cnt_q          <= cnt_d;
      clr_q          <= clr_d;
      lock_pend_q    <= lock_pend_d;
      rd_valid_q     <= rd_valid_d;
      rd_oob_q       <= rd_oob_d;
      clear_pulse_q  <= clear_pulse_d;
      rows_cleared_q <= rows_cleared_d;
      total_lines_q  <= total_lines_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign rd_valid     = rd_valid_q;
  assign rd_data      = (rd_valid_q && !rd_oob_q) ? ram_rdata : '0;
  assign clear_pulse  = clear_pulse_q;
  assign rows_cleared = rows_cleared_q;
  assign total_lines  = total_lines_q;

endmodule

// File: tb/tb_tetris_board_ctrl.sv
// Directed bench for tetris_board_ctrl: init wipe, arbitration, read timing,
// line clears with cycle-exact sequence lengths, and mid-sequence reset.
module tb_tetris_board_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_req, lock_done, rd_req;
  logic [3:0] wr_x, wr_y, wr_color, rd_x, rd_y;
  logic       wr_ack, rd_ack, rd_valid, busy, clear_pulse;
  logic [3:0] rd_data;
  logic [2:0] rows_cleared;
  logic [9:0] total_lines;

  int checks = 0;
  int errors = 0;

  tetris_board_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_req      (wr_req),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .wr_ack      (wr_ack),
    .lock_done   (lock_done),
    .rd_req      (rd_req),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .busy        (busy),
    .clear_pulse (clear_pulse),
    .rows_cleared(rows_cleared),
    .total_lines (total_lines)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] x, input logic [3:0] y, input logic [3:0] c);
    int n;
    wr_req = 1'b1; wr_x = x; wr_y = y; wr_color = c;
    #1;
    n = 0;
    while (!wr_ack && n < 2000) begin tick(); n++; end
    chk("wr_ack_wait", wr_ack, 1);
    tick();
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] x, input logic [3:0] y, output logic [3:0] d);
    int n;
    rd_req = 1'b1; rd_x = x; rd_y = y;
    #1;
    n = 0;
    while (!rd_ack && n < 2000) begin tick(); n++; end
    chk("rd_ack_wait", rd_ack, 1);
    tick();
    rd_req = 1'b0;
    chk("rd_valid_next", rd_valid, 1);
    d = rd_data;
  endtask

  task automatic count_nonzero_board(output int nz);
    logic [3:0] d;
    nz = 0;
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < 10; x++) begin
        do_read(4'(x), 4'(y), d);
        if (d != 4'd0) nz++;
      end
  endtask

  initial begin
    int         n, nz;
    logic       seen;
    logic [3:0] d;

    reset_n = 1'b0; wr_req = 1'b0; lock_done = 1'b0; rd_req = 1'b0;
    wr_x = '0; wr_y = '0; wr_color = '0; rd_x = '0; rd_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_clear_pulse", clear_pulse, 0);
    chk("rst_rows_cleared", rows_cleared, 0);
    chk("rst_total_lines", total_lines, 0);

    // Init wipe with a read held pending the whole time.
    reset_n = 1'b1; rd_req = 1'b1; rd_x = 4'd0; rd_y = 4'd0;
    #1;
    n = 0; seen = 1'b0;
    while (busy && n < 500) begin seen |= rd_ack; tick(); n++; end
    chk("init_cycles", n, 120);
    chk("init_no_rd_ack", seen, 0);
    chk("init_rd_ack_after", rd_ack, 1);
    tick();
    rd_req = 1'b0;
    chk("init_rd_valid", rd_valid, 1);
    chk("init_rd_00", rd_data, 0);
    do_read(4'd9, 4'd11, d);
    chk("init_rd_9_11", d, 0);

    // Write then read back, with a same-cell write right behind the read.
    wr_req = 1'b1; wr_x = 4'd3; wr_y = 4'd5; wr_color = 4'd7;
    #1;
    chk("wr_ack_comb", wr_ack, 1);
    tick();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_x = 4'd3; rd_y = 4'd5;
    #1;
    chk("rd_ack_comb", rd_ack, 1);
    chk("rd_valid_in_ack_cycle", rd_valid, 0);
    tick();
    rd_req = 1'b0;
    wr_req = 1'b1; wr_x = 4'd3; wr_y = 4'd5; wr_color = 4'd9;
    #1;
    chk("rd_valid_3_5", rd_valid, 1);
    chk("rd_data_3_5", rd_data, 7);
    chk("wr_ack_after_rd", wr_ack, 1);
    tick();
    wr_req = 1'b0;
    chk("rd_valid_one_cycle", rd_valid, 0);
    do_read(4'd3, 4'd5, d);
    chk("rd_3_5_overwritten", d, 9);
    do_read(4'd10, 4'd0, d);
    chk("rd_oob_x", d, 0);
    do_write(4'd10, 4'd0, 4'd3);
    do_read(4'd0, 4'd1, d);
    chk("wr_oob_dropped", d, 0);
    do_read(4'd0, 4'd12, d);
    chk("rd_oob_y", d, 0);

    // Simultaneous write and read: write first, read next cycle.
    wr_req = 1'b1; wr_x = 4'd2; wr_y = 4'd2; wr_color = 4'd6;
    rd_req = 1'b1; rd_x = 4'd3; rd_y = 4'd5;
    #1;
    chk("both_wr_ack", wr_ack, 1);
    chk("both_rd_blocked", rd_ack, 0);
    tick();
    wr_req = 1'b0;
    #1;
    chk("both_rd_ack_next", rd_ack, 1);
    tick();
    rd_req = 1'b0;
    chk("both_rd_data", rd_data, 9);
    do_read(4'd2, 4'd2, d);
    chk("both_wr_landed", d, 6);
    do_write(4'd2, 4'd2, 4'd0);
    do_write(4'd3, 4'd5, 4'd0);

    // Single full row with one cell above it.
    for (int x = 0; x < 10; x++) do_write(4'(x), 4'd11, 4'd2);
    do_write(4'd4, 4'd10, 4'd5);
    lock_done = 1'b1;
    tick();
    lock_done = 1'b0;
    rd_req = 1'b1; rd_x = 4'd4; rd_y = 4'd11;
    #1;
    n = 0; seen = 1'b0;
    while (!busy && n < 10) begin seen |= rd_ack; tick(); n++; end
    chk("clr1_started", busy, 1);
    n = 0;
    while (busy && n < 3000) begin seen |= rd_ack; tick(); n++; end
    chk("clr1_busy_cycles", n, 373);
    chk("clr1_rd_held_off", seen, 0);
    chk("clr1_clear_pulse", clear_pulse, 1);
    chk("clr1_rows_cleared", rows_cleared, 1);
    chk("clr1_total_lines", total_lines, 1);
    chk("clr1_rd_ack_idle", rd_ack, 1);
    tick();
    rd_req = 1'b0;
    chk("clr1_pulse_one_cycle", clear_pulse, 0);
    chk("clr1_rd_4_11", rd_data, 5);
    do_read(4'd4, 4'd10, d);
    chk("clr1_rd_4_10", d, 0);
    nz = 0;
    for (int x = 0; x < 10; x++) begin
      do_read(4'(x), 4'd0, d);
      if (d != 4'd0) nz++;
    end
    chk("clr1_row0_zero", nz, 0);
    do_write(4'd4, 4'd11, 4'd0);

    // Four full rows; the last write arrives together with lock_done.
    for (int y = 8; y < 12; y++)
      for (int x = 0; x < 10; x++)
        if (!(y == 11 && x == 9)) do_write(4'(x), 4'(y), 4'(y - 7));
    wr_req = 1'b1; wr_x = 4'd9; wr_y = 4'd11; wr_color = 4'd4; lock_done = 1'b1;
    #1;
    chk("clr4_wr_with_lock_ack", wr_ack, 1);
    chk("clr4_not_busy_yet", busy, 0);
    tick();
    wr_req = 1'b0; lock_done = 1'b0;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    chk("clr4_started", busy, 1);
    n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    chk("clr4_busy_cycles", n, 964);
    chk("clr4_clear_pulse", clear_pulse, 1);
    chk("clr4_rows_cleared", rows_cleared, 4);
    chk("clr4_total_lines", total_lines, 5);
    count_nonzero_board(nz);
    chk("clr4_board_empty", nz, 0);

    // Reset in the middle of a shift, with a second lock_done latched.
    for (int x = 0; x < 10; x++) do_write(4'(x), 4'd11, 4'd3);
    lock_done = 1'b1;
    tick();
    lock_done = 1'b0;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    chk("rst_seq_started", busy, 1);
    lock_done = 1'b1;
    tick();
    lock_done = 1'b0;
    repeat (11) tick();
    chk("rst_at_shift_wr", 32'(dut.state_q), 32'(tetris_pkg::S_SHIFT_WR));
    reset_n = 1'b0;
    tick();
    chk("rst_mid_busy", busy, 1);
    tick();
    reset_n = 1'b1;
    #1;
    n = 0;
    while (busy && n < 500) begin tick(); n++; end
    chk("rst_mid_init_cycles", n, 120);
    chk("rst_mid_total_lines", total_lines, 0);
    chk("rst_mid_rows_cleared", rows_cleared, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin seen |= busy; tick(); end
    chk("rst_mid_lock_pend_cleared", seen, 0);
    count_nonzero_board(nz);
    chk("rst_mid_board_empty", nz, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
